// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner
//   Scanner/encoder for a 4x4 hex keypad. It drives the columns one at a time,
//   reads the rows, debounces the press and the release, and reports a 4-bit
//   key code (4*row + col).
//
// Parameters
//   SETTLE_CYCLES  cycles a column is driven before the rows are sampled (>=1)
//   DEBOUNCE_CNT   consecutive stable samples needed for a press and for a release (>=1)
//
// Ports
//   clock    in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   row[3:0] in   row sense lines, active-high, sampled directly
//   col[3:0] out  column drive lines, active-high, registered
//   code[3:0]out  key code, updated on valid and held until the next accepted press
//   valid    out  one-cycle pulse when a debounced press is accepted
//   pressed  out  high from valid until the debounced release
//   multi    out  more than one row was seen in the accepted column (cleared on release)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | all columns driven, waiting for any row to go high
// SCAN     | one column driven; sample rows once it has settled
// CONFIRM  | captured column held; count stable samples of the captured row
// HOLD     | key accepted; count consecutive clear samples for release
module hex_keypad_scanner #(
  parameter int SETTLE_CYCLES = 4,
  parameter int DEBOUNCE_CNT  = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] code,
  output logic       valid,
  output logic       pressed,
  output logic       multi
);

  localparam int MAX_CNT = (SETTLE_CYCLES > DEBOUNCE_CNT) ? SETTLE_CYCLES : DEBOUNCE_CNT;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DB_TARGET   = CW'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_CONFIRM,
    ST_HOLD
  } state_t;

  state_t        state_q,   state_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [CW-1:0] settle_q,  settle_d;
  logic [CW-1:0] db_q,      db_d;
  logic [CW-1:0] rel_q,     rel_d;
  logic [3:0]    col_q,     col_d;
  logic [3:0]    code_q,    code_d;
  logic          valid_q,   valid_d;
  logic          pressed_q, pressed_d;
  logic          multi_q,   multi_d;

  // Lowest set row wins when several rows of one column are active.
  function automatic logic [1:0] lowest_bit(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (v[0])      idx = 2'd0;
    else if (v[1]) idx = 2'd1;
    else if (v[2]) idx = 2'd2;
    else if (v[3]) idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [3:0] one_hot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    settle_d  = settle_q;
    db_d      = db_q;
    rel_d     = rel_q;
    col_d     = col_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    pressed_d = pressed_q;
    multi_d   = multi_q;

    case (state_q)
      ST_IDLE: begin
        col_d = 4'hF;
        if (row != 4'h0) begin
          state_d   = ST_SCAN;
          col_idx_d = 2'd0;
          settle_d  = '0;
          col_d     = one_hot(2'd0);
        end
      end

      ST_SCAN: begin
        if (settle_q == SETTLE_LAST) begin
          if (row == 4'h0) begin
            if (col_idx_q == 2'd3) begin
              // Nothing found in any column: the IDLE wake-up was spurious.
              state_d = ST_IDLE;
              col_d   = 4'hF;
            end else begin
              col_idx_d = col_idx_q + 2'd1;
              settle_d  = '0;
              col_d     = one_hot(col_idx_q + 2'd1);
            end
          end else begin
            row_idx_d = lowest_bit(row);
            // v & (v-1) clears the lowest set bit; anything left means >1 row.
            multi_d   = ((row & (row - 4'd1)) != 4'h0);
            if (DEBOUNCE_CNT == 1) begin
              state_d   = ST_HOLD;
              code_d    = {lowest_bit(row), col_idx_q};
              valid_d   = 1'b1;
              pressed_d = 1'b1;
              rel_d     = '0;
            end else begin
              state_d = ST_CONFIRM;
              db_d    = CW'(1);
            end
          end
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      ST_CONFIRM: begin
        if (row[row_idx_q]) begin
          if ((db_q + 1'b1) == DB_TARGET) begin
            state_d   = ST_HOLD;
            code_d    = {row_idx_q, col_idx_q};
            valid_d   = 1'b1;
            pressed_d = 1'b1;
            db_d      = '0;
            rel_d     = '0;
          end else begin
            db_d = db_q + 1'b1;
          end
        end else begin
          // Bounce: drop the candidate without reporting it.
          state_d = ST_IDLE;
          db_d    = '0;
          multi_d = 1'b0;
          col_d   = 4'hF;
        end
      end

      ST_HOLD: begin
        // Only the captured row matters; other keys are ignored until release.
        if (!row[row_idx_q]) begin
          if ((rel_q + 1'b1) == DB_TARGET) begin
            state_d   = ST_IDLE;
            pressed_d = 1'b0;
            multi_d   = 1'b0;
            rel_d     = '0;
            col_d     = 4'hF;
          end else begin
            rel_d = rel_q + 1'b1;
          end
        end else begin
          rel_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        col_d   = 4'hF;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      col_idx_q <= 2'd0;
      row_idx_q <= 2'd0;
      settle_q  <= '0;
      db_q      <= '0;
      rel_q     <= '0;
      col_q     <= 4'hF;
      code_q    <= 4'h0;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      row_idx_q <= row_idx_d;
      settle_q  <= settle_d;
      db_q      <= db_d;
      rel_q     <= rel_d;
      col_q     <= col_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      pressed_q <= pressed_d;
      multi_q   <= multi_d;
    end
  end

  assign col     = col_q;
  assign code    = code_q;
  assign valid   = valid_q;
  assign pressed = pressed_q;
  assign multi   = multi_q;

endmodule
